// File: rtl/ctl_seq_pkg.sv
// ctl_seq_pkg: state encoding and reset constants shared by the ctl_seq sequencer.
// Rev 1.0
`default_nettype none

package ctl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } ctl_seq_state_t;

  localparam int unsigned PAT_RST = 0;
  localparam int unsigned IDX_RST = 0;
  localparam int unsigned CNT_RST = 0;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// sync2: generic two-flop synchronizer with synchronous active-high reset.
// Rev 1.0
`default_nettype none

module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctl_seq.sv
// ctl_seq: control-token sequencer driving a 4-phase bundled-data handshake.
// Rev 1.0 -- define CTL_SEQ_SYNC_EN to pass actl_i through a two-flop synchronizer.
`default_nettype none

module ctl_seq
  import ctl_seq_pkg::*;
#(
  parameter  int LEN = 8,
  parameter  int CW  = 16,
  localparam int IW  = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] nburst,
  input  logic          stop,
  input  logic          ld,
  input  logic [LEN-1:0] pat_i,
  output logic          rctl_o,
  output logic          dctl_o,
  input  logic          actl_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] idx_o
);

  ctl_seq_state_t state;
  logic [LEN-1:0] pat;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  nb;
  logic           stop_flag;
  logic           rctl;
  logic           dctl;
  logic           done;
  logic           ack;

  logic [IW-1:0]  idx_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic           last;

`ifdef CTL_SEQ_SYNC_EN
  sync2 #(
    .W (1)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (actl_i),
    .q   (ack)
  );
`else
  assign ack = actl_i;
`endif

  // Index wraps explicitly so non-power-of-two pattern lengths work.
  assign idx_nxt = (idx == IW'(LEN - 1)) ? '0 : idx + 1'b1;
  assign cnt_nxt = cnt + 1'b1;
  assign last    = stop_flag | stop | ((nb != '0) && (cnt_nxt == nb));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat       <= LEN'(PAT_RST);
      idx       <= IW'(IDX_RST);
      cnt       <= CW'(CNT_RST);
      nb        <= '0;
      stop_flag <= 1'b0;
      rctl      <= 1'b0;
      dctl      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A load in the same cycle as start lands first, so the burst sees it.
          if (ld) begin
            pat <= pat_i;
            idx <= IW'(IDX_RST);
          end
          if (start) begin
            state     <= SETUP;
            nb        <= nburst;
            cnt       <= CW'(CNT_RST);
            stop_flag <= 1'b0;
          end
        end
        SETUP: begin
          dctl      <= pat[idx];
          rctl      <= 1'b1;
          stop_flag <= stop_flag | stop;
          state     <= REQ;
        end
        REQ: begin
          stop_flag <= stop_flag | stop;
          if (ack) begin
            rctl  <= 1'b0;
            state <= REL;
          end
        end
        REL: begin
          stop_flag <= stop_flag | stop;
          if (!ack) begin
            idx <= idx_nxt;
            cnt <= cnt_nxt;
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rctl_o = rctl;
  assign dctl_o = dctl;
  assign busy_o = (state != IDLE);
  assign done_o = done;
  assign idx_o  = idx;

endmodule

`default_nettype wire

// File: tb/tb_ctl_seq.sv
// tb_ctl_seq: table-driven bench for ctl_seq with a bench-side acknowledge responder.
// Rev 1.0 -- ack latency expectation follows CTL_SEQ_SYNC_EN.
`default_nettype none

module tb_ctl_seq;

  localparam int LEN = 8;
  localparam int CW  = 16;
  localparam int IW  = 3;
`ifdef CTL_SEQ_SYNC_EN
  localparam int EXP_ACK_EDGES = 3;
`else
  localparam int EXP_ACK_EDGES = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [CW-1:0]  nburst;
  logic           stop;
  logic           ld;
  logic [LEN-1:0] pat;
  logic           rctl;
  logic           dctl;
  logic           actl;
  logic           busy;
  logic           done;
  logic [IW-1:0]  idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        do_ld;
    logic [7:0]  pat;
    logic [15:0] nb;
    int          stop_tok;
    int          dis_tok;
    int          exp_tok;
    logic [15:0] exp_bits;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t vecs[9];
  vec_t rv;

  ctl_seq #(
    .LEN (LEN),
    .CW  (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .nburst (nburst),
    .stop   (stop),
    .ld     (ld),
    .pat_i  (pat),
    .rctl_o (rctl),
    .dctl_o (dctl),
    .actl_i (actl),
    .busy_o (busy),
    .done_o (done),
    .idx_o  (idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Starts a burst, answers every request one cycle later, injects stop / ignored
  // inputs at the requested token, then compares the captured token stream.
  task automatic run_burst(input int n, input vec_t v);
    int          tok   = 0;
    int          dones = 0;
    logic [15:0] bits  = '0;
    bit          ok    = 1'b0;
    @(negedge clk);
    ld = v.do_ld; pat = v.pat; nburst = v.nb; start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      ld = 1'b0; start = 1'b0; stop = 1'b0; nburst = v.nb; pat = v.pat;
      if (done) dones++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (rctl && !actl) begin
        if (tok < 16) bits[tok] = dctl;
        tok++;
        actl = 1'b1;
        if (tok == v.stop_tok) stop = 1'b1;
      end else if (!rctl && actl) begin
        actl = 1'b0;
        if (tok == v.dis_tok) begin
          ld = 1'b1; pat = '0; start = 1'b1; nburst = 16'd1;
        end
      end
    end
    ld = 1'b0; start = 1'b0; stop = 1'b0; actl = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL v%0d timeout busy=%0b want=0", n, busy);
    end
    check($sformatf("v%0d tokens", n), tok, v.exp_tok);
    check($sformatf("v%0d dctl_bits", n), bits, v.exp_bits);
    check($sformatf("v%0d idx_end", n), idx, v.exp_idx);
    check($sformatf("v%0d done_count", n), dones, 1);
    @(negedge clk);
    check($sformatf("v%0d done_width", n), done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int dones;
    //                 ld    pat    nb      stop dis tok bits      idx
    vecs[0] = '{1'b1, 8'hA6, 16'd4,  0, 0, 4,  16'h0006, 3'd4};
    vecs[1] = '{1'b1, 8'hA6, 16'd10, 0, 0, 10, 16'h02A6, 3'd2};
    vecs[2] = '{1'b0, 8'hA6, 16'd3,  0, 0, 3,  16'h0001, 3'd5};
    vecs[3] = '{1'b1, 8'hA6, 16'd0,  3, 0, 3,  16'h0006, 3'd3};
    vecs[4] = '{1'b0, 8'hA6, 16'd4,  0, 2, 4,  16'h0004, 3'd7};
    vecs[5] = '{1'b0, 8'hA6, 16'd1,  0, 0, 1,  16'h0001, 3'd0};
    vecs[6] = '{1'b1, 8'h01, 16'd2,  0, 0, 2,  16'h0001, 3'd2};
    vecs[7] = '{1'b0, 8'h01, 16'd8,  0, 0, 8,  16'h0040, 3'd2};
    vecs[8] = '{1'b1, 8'hFF, 16'd1,  0, 0, 1,  16'h0001, 3'd1};

    rst = 1'b1; start = 1'b0; nburst = '0; stop = 1'b0; ld = 1'b0; pat = '0; actl = 1'b0;
    repeat (3) @(negedge clk);
    check("rst rctl", rctl, 1'b0);
    check("rst dctl", dctl, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst idx", idx, 3'd0);
    rst = 1'b0;

    // Start latency and acknowledge-to-release latency.
    @(negedge clk);
    nburst = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat busy_after_start", busy, 1'b1);
    check("lat rctl_in_setup", rctl, 1'b0);
    @(negedge clk);
    check("lat rctl_in_req", rctl, 1'b1);
    actl  = 1'b1;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      edges++;
      if (!rctl) break;
    end
    check("ack_to_rctl_fall_edges", edges, EXP_ACK_EDGES);
    actl  = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (!busy) break;
    end
    check("lat busy_end", busy, 1'b0);
    check("lat done_count", dones, 1);

    for (int v = 0; v < 9; v++) run_burst(v, vecs[v]);

    // Reset while a request is outstanding.
    @(negedge clk);
    nburst = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rctl) break;
      @(negedge clk);
    end
    check("mid rctl_before_rst", rctl, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid rctl", rctl, 1'b0);
    check("mid dctl", dctl, 1'b0);
    check("mid busy", busy, 1'b0);
    check("mid done", done, 1'b0);
    check("mid idx", idx, 3'd0);
    rst = 1'b0;
    rv = '{1'b0, 8'hFF, 16'd2, 0, 0, 2, 16'h0000, 3'd2};
    run_burst(9, rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
